// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cpu_pkg                                                    |
// | Purpose : Constants and types shared by the ARM-subset pipeline.     |
// |           ADDR_W    - PC / instruction word-address width            |
// |           HALT_WORD - B #-1 (cond AL), the self-loop halt encoding   |
// |           NOP       - MOV r0,r0, used by decode-stage flushes        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int          ADDR_W    = 32;
  localparam logic [31:0] HALT_WORD = 32'hEAFF_FFFF;
  localparam logic [31:0] NOP       = 32'hE1A0_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_id_register.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : if_id_register                                             |
// | Purpose : IF/ID pipeline register.                                   |
// |   clock, reset_n   : clock, async active-low reset                   |
// |   load             : capture in_instruction / in_pc_next, set valid  |
// |   hold             : keep every field unchanged                      |
// |   clear_valid      : drop valid only; data fields keep old value     |
// |   id_instruction, id_pc_next, id_valid : register outputs            |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module if_id_register
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              hold,
  input  logic              clear_valid,
  input  logic [31:0]       in_instruction,
  input  logic [ADDR_W-1:0] in_pc_next,
  output logic [31:0]       id_instruction,
  output logic [ADDR_W-1:0] id_pc_next,
  output logic              id_valid
);

  logic [31:0]       r_instruction;
  logic [ADDR_W-1:0] r_pc_next;
  logic              r_valid;

  // clear_valid wins over hold so a redirect can squash a frozen slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_instruction <= '0;
      r_pc_next     <= '0;
      r_valid       <= 1'b0;
    end else if (clear_valid) begin
      r_valid       <= 1'b0;
    end else if (hold) begin
      r_valid       <= r_valid;
    end else if (load) begin
      r_instruction <= in_instruction;
      r_pc_next     <= in_pc_next;
      r_valid       <= 1'b1;
    end
  end

  assign id_instruction = r_instruction;
  assign id_pc_next     = r_pc_next;
  assign id_valid       = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fetch_stage                                                |
// | Purpose : Instruction fetch. Owns the PC, the BOOT/RUN/HALT FSM and  |
// |           the fetch counter; feeds the IF/ID register.               |
// |   clock, reset_n        : clock, async active-low reset              |
// |   freeze                : stall, holds PC and IF/ID                  |
// |   branch_taken/_target  : EX redirect (word address)                 |
// |   instr_address         : PC to combinational instruction memory     |
// |   instruction           : word returned in the same cycle            |
// |   id_instruction/_pc_next/_valid : IF/ID outputs                     |
// |   halted                : stage is in HALT                           |
// |   fetch_count           : valid IF/ID loads since reset (wraps)      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fetch_stage
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] instr_address,
  input  logic [31:0]       instruction,
  output logic [31:0]       id_instruction,
  output logic [ADDR_W-1:0] id_pc_next,
  output logic              id_valid,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  localparam logic [1:0] ST_BOOT = BOOT;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_HALT = HALT;

  localparam logic [ADDR_W-1:0] c_pc_one  = ADDR_W'(1);
  localparam logic [31:0]       c_cnt_one = 32'd1;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_fetch_count;

  logic              w_in_boot;
  logic              w_in_run;
  logic              w_in_halt;
  logic              w_is_halt_word;
  logic              w_load;
  logic              w_clear_valid;
  logic              w_hold;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_in_boot      = (r_state == ST_BOOT);
  assign w_in_run       = (r_state == ST_RUN);
  assign w_in_halt      = (r_state == ST_HALT);
  assign w_is_halt_word = (instruction == HALT_WORD);
  assign w_pc_inc       = r_pc + c_pc_one;

  // Branch outranks freeze; both are ignored during BOOT.
  assign w_load        = w_in_run && !branch_taken && !freeze;
  assign w_clear_valid = !w_in_boot && (branch_taken || (w_in_halt && !freeze));
  assign w_hold        = freeze;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= '0;
      r_fetch_count <= '0;
    end else if (w_in_boot) begin
      r_state       <= ST_RUN;
    end else if (branch_taken) begin
      // Also leaves HALT: the halt word was on a wrong path.
      r_pc          <= branch_target;
      r_state       <= ST_RUN;
    end else if (w_load) begin
      r_fetch_count <= r_fetch_count + c_cnt_one;
      if (w_is_halt_word) begin
        r_state     <= ST_HALT;
      end else begin
        r_pc        <= w_pc_inc;
      end
    end
  end

  if_id_register u_if_id (
    .clock          (clock),
    .reset_n        (reset_n),
    .load           (w_load),
    .hold           (w_hold),
    .clear_valid    (w_clear_valid),
    .in_instruction (instruction),
    .in_pc_next     (w_pc_inc),
    .id_instruction (id_instruction),
    .id_pc_next     (id_pc_next),
    .id_valid       (id_valid)
  );

  assign instr_address = r_pc;
  assign halted        = w_in_halt;
  assign fetch_count   = r_fetch_count;

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined ARM-subset core.
- Owns the program counter and drives the word address into the instruction memory, whose read is combinational.
- Captures the returned word into the IF/ID pipeline register for decode.
- Honours stall (freeze) and branch-redirect requests from later stages.
- Detects the self-loop halt word, stops fetching and raises a status flag.

## Interface
- ADDR_W, 32, width of PC and instruction address (word index, not byte address)
- HALT_WORD, 32'hEAFF_FFFF, encoding of B #-1 with cond AL; triggers HALT

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- freeze  in  1  hazard-unit stall; holds PC and IF/ID
- branch_taken  in  1  EX-stage redirect request
- branch_target  in  ADDR_W  word address to redirect to, already computed by EX
- instr_address  out  ADDR_W  address to instruction memory; equals pc
- instruction  in  32  word returned by instruction memory in the same cycle
- id_instruction  out  32  IF/ID instruction register
- id_pc_next  out  ADDR_W  IF/ID copy of fetched pc+1, for branch/link arithmetic
- id_valid  out  1  IF/ID contents are a real instruction
- halted  out  1  stage is in HALT
- fetch_count  out  32  number of valid IF/ID loads since reset; wraps modulo 2^32

## Operation
- States:
  - BOOT: one cycle after reset release; no fetch.
  - RUN.
  - HALT.
- Reset (async, reset_n=0) forces:
  - pc=0, state=BOOT.
  - id_instruction=0, id_pc_next=0, id_valid=0.
  - halted=0, fetch_count=0.
- BOOT → RUN on the first edge. pc stays 0 and id_valid stays 0 on that edge; branch and freeze are ignored in BOOT.
- Edge actions in RUN and HALT, in priority order:
  1. branch_taken=1 (overrides freeze)
     - pc←branch_target, id_valid←0, state←RUN.
     - id_instruction and id_pc_next are don't-care but hold their old value.
  2. freeze=1
     - pc, the IF/ID registers, state and fetch_count all hold.
  3. RUN, with instruction≠HALT_WORD
     - id_instruction←instruction, id_pc_next←pc+1, id_valid←1.
     - pc←pc+1, fetch_count+1.
  4. RUN, with instruction==HALT_WORD
     - IF/ID is loaded as in case 3 (id_valid←1) and fetch_count increments.
     - pc holds (no increment) and state←HALT.
  5. HALT
     - id_valid←0; pc holds at the halt word's address.
- halted = (state==HALT), decoded combinationally from the state register.
- PC arithmetic is ADDR_W-bit unsigned and wraps from 2^ADDR_W−1 to 0 without error.
- A branch arriving in HALT comes from an older in-flight instruction, so the halt word was on a wrong path. The stage returns to RUN and halted drops on that edge.
- A branch in the same cycle as the halt word is fetched takes priority: the halt word is discarded and HALT is not entered.

## Timing
- instr_address is registered (pc). instruction is sampled at the edge ending the cycle in which it was presented.
- Fetch-to-ID latency is 1 cycle. Throughput is 1 instruction/cycle when freeze=0.
- Branch penalty at this stage is one bubble: id_valid=0 for the cycle after redirect, and the target reaches ID on the second edge.
- freeze has no internal latency: the held cycle repeats the same instr_address.
- reset_n assertion mid-operation clears state immediately, without waiting for a clock edge. Deassertion is followed by one BOOT cycle before the first fetch.
- fetch_count and halted change only on clock edges (or async reset).

## Structure
- Shared package cpu_pkg:
  - ADDR_W and HALT_WORD constants.
  - fetch_state_t enum {BOOT, RUN, HALT}.
  - NOP constant, shared with the decode-stage flush logic.
- One sub-module, if_id_register. It holds id_instruction, id_pc_next and id_valid, with load, hold and clear_valid controls.
- The PC, state machine and counter live in fetch_stage.

## Test plan
- Reset then run, memory words 0..3 = W0..W3, freeze=0:
  - instr_address goes 0,0(BOOT),1,2,3.
  - id_instruction goes W0,W1,W2 with id_pc_next 1,2,3.
  - fetch_count reaches 3 after 3 fetches.
- Freeze at pc=5 for 3 cycles:
  - instr_address stays 5 and IF/ID holds word 4 with id_pc_next 5.
  - On release, word 5 loads with id_pc_next 6 and no instruction is lost or duplicated.
- branch_taken=1, target=28, with freeze=1 in the same cycle:
  - Next cycle: pc=28, id_valid=0.
  - Following edge: word 28 in ID with id_pc_next 29.
- Halt: word 46=32'hEAFFFFFF reached sequentially.
  - halted=1 after the load edge; ID holds the halt word with id_valid=1 for one cycle, then id_valid=0.
  - pc stays 46 and fetch_count stops.
- In HALT, branch_taken=1 to 37:
  - halted=0 and pc=37 after the edge, then normal fetch resumes.
  - Separately, branch in the same cycle the halt word is presented: HALT is never entered.
- Mid-run async reset at pc=20, asserted between edges:
  - All outputs zero immediately.
  - After release: one BOOT cycle, then fetch restarts at 0.
